// File: rtl/weight_addrgen_pkg.sv
// weight_addrgen_pkg: shared types and helpers for the weight address generator.
// Provides the FSM state enum, counter width helper and address span check.
package weight_addrgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter running 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when the whole weight window fits in the address space.
  function automatic bit span_ok(
    input int aw,
    input int ports,
    input int cyc,
    input int mult
  );
    longint span;
    longint lim;
    span = longint'(ports) * longint'(cyc) * longint'(mult);
    lim  = longint'(1) << aw;
    return span <= lim;
  endfunction

endpackage

// File: rtl/addrgen_loop_cnt.sv
// addrgen_loop_cnt: wrapping counter 0..i_max, one level of the loop nest.
// Ports: i_inc advance, i_clr clear, i_max wrap value; o_cnt, o_last, o_wrap.
module addrgen_loop_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_cnt,
  output logic         o_last,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == i_max);
  assign o_wrap = i_inc & o_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/weight_addrgen_multiport.sv
// weight_addrgen_multiport: multi-port weight RAM address generator.
// Ports: clk, reset_n, start, abort, enable, base_addr (WADDR_BASE_EN only);
//   addr (port p at [p*W +: W]), addr_vld, pixel_last, run_last, busy, done.
module weight_addrgen_multiport
  import weight_addrgen_pkg::*;
#(
  parameter int WEIGHT_ADDR_WIDTH   = 16,
  parameter int NUM_PORTS           = 2,
  parameter int NUM_ONE_PIXEL_CYCLE = 9,
  parameter int NUM_OUTPIXEL        = 784,
  parameter int NUM_ONEMULT         = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic enable,
`ifdef WADDR_BASE_EN
  input  logic [WEIGHT_ADDR_WIDTH-1:0] base_addr,
`endif
  output logic [NUM_PORTS*WEIGHT_ADDR_WIDTH-1:0] addr,
  output logic addr_vld,
  output logic pixel_last,
  output logic run_last,
  output logic busy,
  output logic done
);

  localparam int AW = WEIGHT_ADDR_WIDTH;
  localparam int BW = cnt_w(NUM_ONE_PIXEL_CYCLE);
  localparam int PW = cnt_w(NUM_OUTPIXEL);
  localparam int MW = cnt_w(NUM_ONEMULT);

  localparam logic [BW-1:0] BMAX = BW'(NUM_ONE_PIXEL_CYCLE - 1);
  localparam logic [PW-1:0] PMAX = PW'(NUM_OUTPIXEL - 1);
  localparam logic [MW-1:0] MMAX = MW'(NUM_ONEMULT - 1);

  if (!span_ok(AW, NUM_PORTS, NUM_ONE_PIXEL_CYCLE, NUM_ONEMULT)) begin : g_span
    $error("weight window does not fit in WEIGHT_ADDR_WIDTH");
  end

  state_e r_state;
  state_e w_nstate;

  logic w_fire;
  logic w_accept;
  logic w_clr;

  logic [BW-1:0] w_beat;
  logic [PW-1:0] w_pix;
  logic [MW-1:0] w_mult;
  logic w_beat_last, w_beat_wrap;
  logic w_pix_last, w_pix_wrap;
  logic w_mult_last, w_mult_wrap;

  logic [AW-1:0] w_base;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_stride;
  logic [NUM_PORTS*AW-1:0] w_addr;

  logic [NUM_PORTS*AW-1:0] r_addr;
  logic r_vld;
  logic r_pix_last;
  logic r_run_last;

  // Beat issue and run acceptance; abort overrides both.
  always_comb begin
    w_fire   = (r_state == RUN) & enable & ~abort;
    w_accept = (r_state == IDLE) & start & ~abort;
    w_clr    = abort | w_accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // mult wraps exactly on the final beat of the run.
  always_comb begin
    w_nstate = r_state;
    if (abort) begin
      w_nstate = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (start) w_nstate = RUN;
        RUN:  if (w_mult_wrap) w_nstate = DONE;
        DONE: w_nstate = IDLE;
        default: w_nstate = IDLE;
      endcase
    end
  end

  addrgen_loop_cnt #(.W(BW)) u_beat (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_fire),
    .i_clr   (w_clr),
    .i_max   (BMAX),
    .o_cnt   (w_beat),
    .o_last  (w_beat_last),
    .o_wrap  (w_beat_wrap)
  );

  addrgen_loop_cnt #(.W(PW)) u_pix (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_beat_wrap),
    .i_clr   (w_clr),
    .i_max   (PMAX),
    .o_cnt   (w_pix),
    .o_last  (w_pix_last),
    .o_wrap  (w_pix_wrap)
  );

  addrgen_loop_cnt #(.W(MW)) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_pix_wrap),
    .i_clr   (w_clr),
    .i_max   (MMAX),
    .o_cnt   (w_mult),
    .o_last  (w_mult_last),
    .o_wrap  (w_mult_wrap)
  );

`ifdef WADDR_BASE_EN
  logic [AW-1:0] r_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= '0;
    end else if (w_accept) begin
      r_base <= base_addr;
    end
  end

  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  // pix is deliberately absent: every pixel rereads the same window.
  assign w_idx    = AW'(w_mult) * AW'(NUM_ONE_PIXEL_CYCLE) + AW'(w_beat);
  assign w_stride = w_idx * AW'(NUM_PORTS);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_addr[p*AW +: AW] = w_base + w_stride + AW'(p);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_vld      <= 1'b0;
      r_pix_last <= 1'b0;
      r_run_last <= 1'b0;
    end else begin
      r_vld      <= w_fire;
      r_pix_last <= w_beat_wrap;
      r_run_last <= w_mult_wrap;
      if (w_fire) r_addr <= w_addr;
    end
  end

  assign addr       = r_addr;
  assign addr_vld   = r_vld;
  assign pixel_last = r_pix_last;
  assign run_last   = r_run_last;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_weight_addrgen_multiport.sv
// tb_weight_addrgen_multiport: directed table-driven bench for the weight
// address generator across several small configurations.
module tb_weight_addrgen_multiport;

  typedef struct {
    logic        en;
    logic        vld;
    logic        ca;
    logic [63:0] a;
    logic        pl;
    logic        rl;
    logic        dn;
    logic        bz;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic abort;
  logic enable;
  logic start_a, start_b;
  logic [15:0] base0;

  logic [31:0] addr_a;
  logic vld_a, pl_a, rl_a, bz_a, dn_a;
  logic [63:0] addr_b;
  logic vld_b, pl_b, rl_b, bz_b, dn_b;

  int errs = 0;
  int checks = 0;

  row_t tab_a[12];
  row_t tab_b[2];

  weight_addrgen_multiport #(
    .WEIGHT_ADDR_WIDTH(16), .NUM_PORTS(2),
    .NUM_ONE_PIXEL_CYCLE(3), .NUM_OUTPIXEL(2), .NUM_ONEMULT(2)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .abort(abort), .enable(enable),
`ifdef WADDR_BASE_EN
    .base_addr(base0),
`endif
    .addr(addr_a), .addr_vld(vld_a), .pixel_last(pl_a),
    .run_last(rl_a), .busy(bz_a), .done(dn_a)
  );

  weight_addrgen_multiport #(
    .WEIGHT_ADDR_WIDTH(16), .NUM_PORTS(4),
    .NUM_ONE_PIXEL_CYCLE(2), .NUM_OUTPIXEL(1), .NUM_ONEMULT(1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .abort(abort), .enable(enable),
`ifdef WADDR_BASE_EN
    .base_addr(base0),
`endif
    .addr(addr_b), .addr_vld(vld_b), .pixel_last(pl_b),
    .run_last(rl_b), .busy(bz_b), .done(dn_b)
  );

`ifdef WADDR_BASE_EN
  logic start_c, start_d;
  logic [15:0] base_hi;
  logic [31:0] addr_c, addr_d;
  logic vld_c, pl_c, rl_c, bz_c, dn_c;
  logic vld_d, pl_d, rl_d, bz_d, dn_d;

  weight_addrgen_multiport #(
    .WEIGHT_ADDR_WIDTH(16), .NUM_PORTS(2),
    .NUM_ONE_PIXEL_CYCLE(1), .NUM_OUTPIXEL(1), .NUM_ONEMULT(1)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .start(start_c),
    .abort(abort), .enable(enable), .base_addr(base_hi),
    .addr(addr_c), .addr_vld(vld_c), .pixel_last(pl_c),
    .run_last(rl_c), .busy(bz_c), .done(dn_c)
  );

  weight_addrgen_multiport #(
    .WEIGHT_ADDR_WIDTH(16), .NUM_PORTS(2),
    .NUM_ONE_PIXEL_CYCLE(2), .NUM_OUTPIXEL(1), .NUM_ONEMULT(1)
  ) u_d (
    .clk(clk), .reset_n(reset_n), .start(start_d),
    .abort(abort), .enable(enable), .base_addr(base_hi),
    .addr(addr_d), .addr_vld(vld_d), .pixel_last(pl_d),
    .run_last(rl_d), .busy(bz_d), .done(dn_d)
  );
`endif

  function automatic row_t mk(
    input logic en, input logic vld, input logic ca,
    input logic [63:0] a, input logic pl, input logic rl,
    input logic dn, input logic bz
  );
    row_t r;
    r.en = en; r.vld = vld; r.ca = ca; r.a = a;
    r.pl = pl; r.rl = rl; r.dn = dn; r.bz = bz;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic v, output logic [63:0] a,
                        output logic pl, output logic rl,
                        output logic dn, output logic bz);
    v = 0; a = '0; pl = 0; rl = 0; dn = 0; bz = 0;
    case (sel)
      0: begin v = vld_a; a = 64'(addr_a); pl = pl_a;
               rl = rl_a; dn = dn_a; bz = bz_a; end
      1: begin v = vld_b; a = addr_b; pl = pl_b;
               rl = rl_b; dn = dn_b; bz = bz_b; end
`ifdef WADDR_BASE_EN
      2: begin v = vld_c; a = 64'(addr_c); pl = pl_c;
               rl = rl_c; dn = dn_c; bz = bz_c; end
      3: begin v = vld_d; a = 64'(addr_d); pl = pl_d;
               rl = rl_d; dn = dn_d; bz = bz_d; end
`endif
      default: ;
    endcase
  endtask

  // Drive one cycle from the negedge and check the next negedge.
  task automatic apply_row(input int sel, input row_t r, input string nm);
    logic v, pl, rl, dn, bz;
    logic [63:0] a;
    enable = r.en;
    @(posedge clk);
    @(negedge clk);
    sample(sel, v, a, pl, rl, dn, bz);
    chk({nm, ".vld"}, 64'(v), 64'(r.vld));
    chk({nm, ".done"}, 64'(dn), 64'(r.dn));
    chk({nm, ".busy"}, 64'(bz), 64'(r.bz));
    if (r.ca) chk({nm, ".addr"}, a, r.a);
    if (r.vld) begin
      chk({nm, ".pix_last"}, 64'(pl), 64'(r.pl));
      chk({nm, ".run_last"}, 64'(rl), 64'(r.rl));
    end
  endtask

  task automatic start_dut(input int sel, input string nm);
    logic v, pl, rl, dn, bz;
    logic [63:0] a;
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
`ifdef WADDR_BASE_EN
      2: start_c = 1'b1;
      3: start_d = 1'b1;
`endif
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
`ifdef WADDR_BASE_EN
    start_c = 1'b0;
    start_d = 1'b0;
`endif
    sample(sel, v, a, pl, rl, dn, bz);
    chk({nm, ".busy_on_start"}, 64'(bz), 64'd1);
    chk({nm, ".vld_on_start"}, 64'(v), 64'd0);
  endtask

  initial begin
    row_t idle_a, r;
    logic v, pl, rl, dn, bz;
    logic [63:0] a;

    tab_a[0]  = mk(1, 1, 1, 64'h0001_0000, 0, 0, 0, 1);
    tab_a[1]  = mk(1, 1, 1, 64'h0003_0002, 0, 0, 0, 1);
    tab_a[2]  = mk(1, 1, 1, 64'h0005_0004, 1, 0, 0, 1);
    tab_a[3]  = mk(1, 1, 1, 64'h0001_0000, 0, 0, 0, 1);
    tab_a[4]  = mk(1, 1, 1, 64'h0003_0002, 0, 0, 0, 1);
    tab_a[5]  = mk(1, 1, 1, 64'h0005_0004, 1, 0, 0, 1);
    tab_a[6]  = mk(1, 1, 1, 64'h0007_0006, 0, 0, 0, 1);
    tab_a[7]  = mk(1, 1, 1, 64'h0009_0008, 0, 0, 0, 1);
    tab_a[8]  = mk(1, 1, 1, 64'h000B_000A, 1, 0, 0, 1);
    tab_a[9]  = mk(1, 1, 1, 64'h0007_0006, 0, 0, 0, 1);
    tab_a[10] = mk(1, 1, 1, 64'h0009_0008, 0, 0, 0, 1);
    tab_a[11] = mk(1, 1, 1, 64'h000B_000A, 1, 1, 1, 0);
    idle_a    = mk(1, 0, 1, 64'h000B_000A, 0, 0, 0, 0);

    tab_b[0] = mk(1, 1, 1, 64'h0003_0002_0001_0000, 0, 0, 0, 1);
    tab_b[1] = mk(1, 1, 1, 64'h0007_0006_0005_0004, 1, 1, 1, 0);

    reset_n = 1'b0;
    abort   = 1'b0;
    enable  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    base0   = 16'h0000;
`ifdef WADDR_BASE_EN
    start_c = 1'b0;
    start_d = 1'b0;
    base_hi = 16'hFFFE;
`endif

    repeat (2) @(negedge clk);
    sample(0, v, a, pl, rl, dn, bz);
    chk("reset.addr", a, 64'd0);
    chk("reset.vld", 64'(v), 64'd0);
    chk("reset.pix_last", 64'(pl), 64'd0);
    chk("reset.run_last", 64'(rl), 64'd0);
    chk("reset.busy", 64'(bz), 64'd0);
    chk("reset.done", 64'(dn), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full run, enable held high.
    start_dut(0, "run");
    for (int i = 0; i < 12; i++)
      apply_row(0, tab_a[i], $sformatf("run[%0d]", i));
    apply_row(0, idle_a, "run.idle");

    // Same run with enable toggling every cycle.
    start_dut(0, "stall");
    for (int i = 0; i < 12; i++) begin
      apply_row(0, tab_a[i], $sformatf("stall[%0d]", i));
      if (i < 11) begin
        r = mk(0, 0, 1, tab_a[i].a, 0, 0, 0, 1);
        apply_row(0, r, $sformatf("stall.hold[%0d]", i));
      end
    end
    apply_row(0, idle_a, "stall.idle");

    // Four ports, two beats.
    start_dut(1, "p4");
    for (int i = 0; i < 2; i++)
      apply_row(1, tab_b[i], $sformatf("p4[%0d]", i));
    apply_row(1, mk(1, 0, 0, 64'd0, 0, 0, 0, 0), "p4.idle");

    // Abort after beat 5, then a fresh run.
    start_dut(0, "abort");
    for (int i = 0; i < 5; i++)
      apply_row(0, tab_a[i], $sformatf("abort[%0d]", i));
    abort = 1'b1;
    apply_row(0, mk(1, 0, 0, 64'd0, 0, 0, 0, 0), "abort.drop");
    abort = 1'b0;
    for (int i = 0; i < 3; i++)
      apply_row(0, mk(1, 0, 0, 64'd0, 0, 0, 0, 0),
                $sformatf("abort.nodone[%0d]", i));
    start_dut(0, "rerun");
    apply_row(0, tab_a[0], "rerun[0]");
    apply_row(0, tab_a[1], "rerun[1]");

    // Asynchronous reset in the middle of a run.
    for (int i = 2; i < 4; i++)
      apply_row(0, tab_a[i], $sformatf("rst.pre[%0d]", i));
    #2 reset_n = 1'b0;
    #1;
    sample(0, v, a, pl, rl, dn, bz);
    chk("rst.addr", a, 64'd0);
    chk("rst.vld", 64'(v), 64'd0);
    chk("rst.pix_last", 64'(pl), 64'd0);
    chk("rst.run_last", 64'(rl), 64'd0);
    chk("rst.busy", 64'(bz), 64'd0);
    chk("rst.done", 64'(dn), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_dut(0, "rst.fresh");
    apply_row(0, tab_a[0], "rst.fresh[0]");
    apply_row(0, tab_a[1], "rst.fresh[1]");
    abort = 1'b1;
    apply_row(0, mk(1, 0, 0, 64'd0, 0, 0, 0, 0), "rst.abort");
    abort = 1'b0;

`ifdef WADDR_BASE_EN
    start_dut(2, "base1");
    apply_row(2, mk(1, 1, 1, 64'hFFFF_FFFE, 1, 1, 1, 0), "base1[0]");
    start_dut(3, "base2");
    apply_row(3, mk(1, 1, 1, 64'hFFFF_FFFE, 0, 0, 0, 1), "base2[0]");
    apply_row(3, mk(1, 1, 1, 64'h0001_0000, 1, 1, 1, 0), "base2[1]");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
